// File: rtl/frame_sampler_pkg.sv
// Shared state encoding and derived constants for the oversampling receiver.
package frame_sampler_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    function automatic int mid_cnt(input int osr);
        return osr / 2 - 1;
    endfunction

    function automatic int cnt_w(input int osr);
        return $clog2(osr);
    endfunction

    function automatic int idx_w(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/frame_sampler_counter.sv
// Sample counter within one bit period; reports the bit boundary as wrap.
module osr_counter #(
    parameter int MAX = 16,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign wrap_o  = en_i && (cnt_q == W'(MAX - 1));
    assign count_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || wrap_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_sampler.sv
// Oversampling UART-style frame receiver with 3-sample majority voting.
module frame_sampler
    import frame_sampler_pkg::*;
#(
    parameter int OSR        = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rxIn,
    output logic [cnt_w(OSR)-1:0]             bitProgress,
    output logic [idx_w(DATA_BITS)-1:0]       bitIndex,
    output logic                              busy,
    output logic                              sampleStrobe,
    output logic                              bitValue,
    output logic [DATA_BITS-1:0]              dataOut,
    output logic                              frameDone,
    output logic                              frameErr,
    output logic                              parityErr
);

    localparam int CNT_W = cnt_w(OSR);
    localparam int IDX_W = idx_w(DATA_BITS);
    localparam int M     = mid_cnt(OSR);

    localparam logic [CNT_W-1:0] DEC_CNT   = CNT_W'(M + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);
    localparam logic             ODD       = (PARITY_ODD != 0);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       bidx_q, bidx_d;
    logic [DATA_BITS-1:0]   shadow_q, shadow_d;
    logic                   fflag_q, fflag_d;
    logic                   pflag_q, pflag_d;
    logic                   stop_q, stop_d;
    logic [1:0]             smp_q;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   ferr_q, ferr_d;
    logic                   perr_q, perr_d;
    logic                   done_q, done_d;
    logic                   strobe_q, bitval_q;

    logic [CNT_W-1:0]       cnt;
    logic                   wrap;
    logic [2:0]             win;
    logic                   vote;
    logic                   dec;

    osr_counter #(
        .MAX (OSR),
        .W   (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (state_q != S_IDLE),
        .clr_i   (state_d == S_IDLE),
        .count_o (cnt),
        .wrap_o  (wrap)
    );

    // Window holds samples at counts M-1, M and the current one (M+1).
    assign win  = {smp_q, rxIn};
    assign vote = (win[0] & win[1]) | (win[0] & win[2]) | (win[1] & win[2]);
    assign dec  = (state_q != S_IDLE) && (cnt == DEC_CNT);

    always_comb begin
        state_d  = state_q;
        bidx_d   = bidx_q;
        shadow_d = shadow_q;
        fflag_d  = fflag_q;
        pflag_d  = pflag_q;
        stop_d   = stop_q;
        data_d   = data_q;
        ferr_d   = ferr_q;
        perr_d   = perr_q;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                bidx_d = '0;
                if (!rxIn) begin
                    state_d = S_START;
                    fflag_d = 1'b0;
                    pflag_d = 1'b0;
                    stop_d  = 1'b0;
                end
            end
            S_START: begin
                if (dec && vote) begin
                    state_d = S_IDLE;
                end else if (wrap) begin
                    state_d = S_DATA;
                    bidx_d  = '0;
                end
            end
            S_DATA: begin
                if (dec) begin
                    for (int i = 0; i < DATA_BITS; i++) begin
                        if (bidx_q == IDX_W'(i)) shadow_d[i] = vote;
                    end
                end
                if (wrap) begin
                    bidx_d = bidx_q + 1'b1;
                    if (bidx_q == LAST_IDX) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (dec) pflag_d = ((^shadow_q) ^ vote) != ODD;
                if (wrap) state_d = S_STOP;
            end
            S_STOP: begin
                if (dec) begin
                    if (!vote) fflag_d = 1'b1;
                    // Last stop bit: finish at the decision, not the wrap.
                    if (stop_q == LAST_STOP) begin
                        state_d = S_IDLE;
                        data_d  = shadow_q;
                        ferr_d  = fflag_q | ~vote;
                        perr_d  = pflag_q;
                        done_d  = 1'b1;
                    end
                end else if (wrap) begin
                    stop_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            bidx_q   <= '0;
            shadow_q <= '0;
            fflag_q  <= 1'b0;
            pflag_q  <= 1'b0;
            stop_q   <= 1'b0;
            smp_q    <= '0;
            data_q   <= '0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
            done_q   <= 1'b0;
            strobe_q <= 1'b0;
            bitval_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bidx_q   <= bidx_d;
            shadow_q <= shadow_d;
            fflag_q  <= fflag_d;
            pflag_q  <= pflag_d;
            stop_q   <= stop_d;
            smp_q    <= win[1:0];
            data_q   <= data_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
            done_q   <= done_d;
            strobe_q <= dec;
            if (dec) bitval_q <= vote;
        end
    end

    assign bitProgress  = cnt;
    assign bitIndex     = bidx_q;
    assign busy         = (state_q != S_IDLE);
    assign sampleStrobe = strobe_q;
    assign bitValue     = bitval_q;
    assign dataOut      = data_q;
    assign frameDone    = done_q;
    assign frameErr     = ferr_q;
    assign parityErr    = perr_q;

endmodule

// File: tb/tb_frame_sampler.sv
// Scoreboard bench: 8N1 instance plus an 8O1 instance for parity frames.
module tb_frame_sampler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic rxp = 1'b1;

    always #5 clk = ~clk;

    logic [3:0] prog0, prog1;
    logic [3:0] idx0, idx1;
    logic       busy0, busy1, stb0, stb1, bv0, bv1;
    logic [7:0] dout0, dout1;
    logic       done0, done1, ferr0, ferr1, perr0, perr1;

    frame_sampler dut (
        .clk          (clk),
        .rst          (rst),
        .rxIn         (rx),
        .bitProgress  (prog0),
        .bitIndex     (idx0),
        .busy         (busy0),
        .sampleStrobe (stb0),
        .bitValue     (bv0),
        .dataOut      (dout0),
        .frameDone    (done0),
        .frameErr     (ferr0),
        .parityErr    (perr0)
    );

    frame_sampler #(
        .PARITY_EN  (1),
        .PARITY_ODD (1)
    ) dutp (
        .clk          (clk),
        .rst          (rst),
        .rxIn         (rxp),
        .bitProgress  (prog1),
        .bitIndex     (idx1),
        .busy         (busy1),
        .sampleStrobe (stb1),
        .bitValue     (bv1),
        .dataOut      (dout1),
        .frameDone    (done1),
        .frameErr     (ferr1),
        .parityErr    (perr1)
    );

    int checks = 0;
    int errors = 0;
    int nstb0 = 0, nstb1 = 0, ndone0 = 0, ndone1 = 0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] e0, e1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (stb0 === 1'b1) nstb0++;
        if (stb1 === 1'b1) nstb1++;
        if (done0 === 1'b1) begin
            ndone0++;
            if (q0.size() == 0) begin
                check("unexpected_done0", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                check("dataOut0", 32'(dout0), 32'(e0[9:2]));
                check("frameErr0", 32'(ferr0), 32'(e0[1]));
                check("parityErr0", 32'(perr0), 32'(e0[0]));
            end
        end
        if (done1 === 1'b1) begin
            ndone1++;
            if (q1.size() == 0) begin
                check("unexpected_done1", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("dataOut1", 32'(dout1), 32'(e1[9:2]));
                check("frameErr1", 32'(ferr1), 32'(e1[1]));
                check("parityErr1", 32'(perr1), 32'(e1[0]));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Line bit k, cycle j is driven just after edge 16k+j of the frame.
    task automatic send_frame(input bit which, input logic [7:0] d,
                              input bit use_par, input bit pbit,
                              input bit stopv, input int g_bit,
                              input int g_cyc, input int abort_bit);
        logic [11:0] bits;
        int n;
        logic v;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (use_par) begin
            bits[9] = pbit;
            bits[10] = stopv;
            n = 11;
        end else begin
            bits[9] = stopv;
            n = 10;
        end
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 16; j++) begin
                if (k == abort_bit && j == 8) return;
                @(posedge clk);
                #1;
                v = bits[k];
                if (k == g_bit && j == g_cyc) v = ~v;
                if (which) rxp = v;
                else rx = v;
            end
        end
        if (!stopv) begin
            @(posedge clk);
            #1;
            if (which) rxp = 1'b1;
            else rx = 1'b1;
        end
    endtask

    function automatic logic [9:0] exp_p(input logic [7:0] d, input bit pb);
        // Odd parity is good when the total count of ones is odd.
        bit ok;
        ok = (($countones(d) + int'(pb)) % 2) == 1;
        return {d, 1'b0, ~ok};
    endfunction

    int s0, d0, last_prog;
    bit seen;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out0",
              32'({busy0, stb0, bv0, done0, ferr0, perr0, dout0, prog0, idx0}),
              32'd0);
        check("reset_out1",
              32'({busy1, stb1, bv1, done1, ferr1, perr1, dout1, prog1, idx1}),
              32'd0);

        s0 = nstb0;
        d0 = ndone0;
        q0.push_back({8'hA5, 2'b00});
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, -1, -1, -1);
        idle(30);
        check("a5_strobes", 32'(nstb0 - s0), 32'd10);
        check("a5_done_once", 32'(ndone0 - d0), 32'd1);

        d0 = ndone0;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        seen = 1'b0;
        last_prog = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy0) begin
                seen = 1'b1;
                last_prog = int'(prog0);
            end else if (seen) begin
                break;
            end
        end
        check("false_start_seen", 32'(seen), 32'd1);
        check("false_start_cnt", 32'(last_prog), 32'd8);
        check("false_start_busy", 32'(busy0), 32'd0);
        idle(20);
        check("false_start_nodone", 32'(ndone0 - d0), 32'd0);

        q0.push_back({8'h3C, 2'b10});
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, -1, -1, -1);
        idle(40);

        s0 = nstb1;
        q1.push_back(exp_p(8'h01, 1'b1));
        send_frame(1'b1, 8'h01, 1'b1, 1'b1, 1'b1, -1, -1, -1);
        idle(30);
        check("par_strobes", 32'(nstb1 - s0), 32'd11);
        q1.push_back(exp_p(8'h01, 1'b0));
        send_frame(1'b1, 8'h01, 1'b1, 1'b0, 1'b1, -1, -1, -1);
        idle(30);

        d0 = ndone0;
        q0.push_back({8'h55, 2'b00});
        q0.push_back({8'hAA, 2'b00});
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 3, 8, -1);
        send_frame(1'b0, 8'hAA, 1'b0, 1'b0, 1'b1, -1, -1, -1);
        idle(40);
        check("b2b_done_count", 32'(ndone0 - d0), 32'd2);

        d0 = ndone0;
        send_frame(1'b0, 8'hF0, 1'b0, 1'b0, 1'b1, -1, -1, 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        check("midframe_reset",
              32'({busy0, stb0, bv0, done0, ferr0, perr0, dout0, prog0, idx0}),
              32'd0);
        idle(30);
        check("reset_nodone", 32'(ndone0 - d0), 32'd0);
        q0.push_back({8'h0F, 2'b00});
        send_frame(1'b0, 8'h0F, 1'b0, 1'b0, 1'b1, -1, -1, -1);
        idle(40);

        check("sb0_empty", 32'(q0.size()), 32'd0);
        check("sb1_empty", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_sampler.md
FRAME_SAMPLER -- requirements
Module: frame_sampler

Interface
REQ-001 Parameter OSR, default 16: samples per bit; even, >= 4.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; range 5..9.
REQ-003 Parameter PARITY_EN, default 0: 1 inserts a parity bit after the data bits.
REQ-004 Parameter PARITY_ODD, default 0: 1 selects odd parity, 0 selects even parity.
REQ-005 Parameter STOP_BITS, default 1: stop bits per frame; 1 or 2.
REQ-006 clk  input  1: OSR x data-rate clock; the block's only clock.
REQ-007 rst  input  1: reset, synchronous and active-high.
REQ-008 rxIn  input  1: serial line, already synchronised, idle high.
REQ-009 bitProgress  output  clog2(OSR): sample count within the current bit.
REQ-010 bitIndex  output  clog2(DATA_BITS+1): index of the current data bit.
REQ-011 busy  output  1: high whenever state is not IDLE.
REQ-012 sampleStrobe  output  1: one-cycle pulse when a bit decision is made.
REQ-013 bitValue  output  1: majority-voted bit value; valid during sampleStrobe.
REQ-014 dataOut  output  DATA_BITS: received word, LSB first on the line.
REQ-015 frameDone  output  1: one-cycle pulse when a frame completes.
REQ-016 frameErr  output  1: stop bit sampled low; valid during frameDone.
REQ-017 parityErr  output  1: parity mismatch; valid during frameDone; 0 when PARITY_EN=0.

Function
REQ-018 States SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-019 Constant M SHALL equal OSR/2-1.
REQ-020 Each bit's value SHALL be the majority of rxIn at counts M-1, M and M+1.
REQ-021 The decision SHALL be made at count M+1; sampleStrobe and bitValue SHALL be registered and appear one cycle later.
REQ-022 In IDLE, count SHALL be held at 0.
REQ-023 In IDLE, rxIn=0 SHALL move the block to START with count 0 on the next cycle; the detect cycle is not counted.
REQ-024 Outside IDLE, count SHALL increment by 1 each cycle and wrap from OSR-1 to 0; each wrap is one bit boundary.
REQ-025 START, majority 1 (false start): return to IDLE at count M+1; no frameDone; no error.
REQ-026 START, majority 0: continue; at the wrap, enter DATA with bitIndex=0.
REQ-027 DATA: each decision SHALL be written into dataOut shadow register bit[bitIndex].
REQ-028 DATA: at each wrap, bitIndex increments; after bit DATA_BITS-1, go to PARITY if PARITY_EN=1, else to STOP.
REQ-029 PARITY: parityErr flag = (XOR of data bits ^ parity bit) != PARITY_ODD; at the wrap, go to STOP.
REQ-030 STOP: any stop-bit decision of 0 SHALL set the frameErr flag.
REQ-031 The first of two stop bits SHALL run a full bit period before the last stop bit begins.
REQ-032 At the decision of the last stop bit, the block SHALL return to IDLE without waiting for the wrap.
REQ-033 With that return, dataOut, frameErr and parityErr SHALL update from the shadow/flags, and frameDone SHALL pulse for 1 cycle, one cycle later.
REQ-034 dataOut, frameErr and parityErr SHALL hold their values until the next frameDone.
REQ-035 rxIn low in the first IDLE cycle after a frame completes SHALL start a new frame, so back-to-back frames are received with no gap.
REQ-036 sampleStrobe SHALL pulse for every decision, including start, parity and stop bits.

Reset
REQ-037 When rst=1 at a clock edge, the state SHALL become IDLE and count and bitIndex SHALL become 0.
REQ-038 When rst=1 at a clock edge, every output SHALL become 0, including dataOut, busy and all pulses.
REQ-039 rst=1 mid-frame SHALL discard the partial frame and produce no frameDone.
REQ-040 rst SHALL take priority over all other events.

Structure
REQ-041 A shared package SHALL hold the state encoding and the M and width constants (derived with clog2).
REQ-042 The block SHALL contain one sub-module, osr_counter: parametrised count, enable and clear, reporting count and wrap.
REQ-043 The majority vote SHALL be done inline as a 3-entry sample shift register.

Verification (OSR=16, DATA_BITS=8, 8N1 unless stated)
REQ-044 Bench SHALL drive 0xA5 framed 8N1 -> dataOut=0xA5, frameDone exactly once, frameErr=0, and 10 sampleStrobe pulses in total.
REQ-045 Bench SHALL drive rxIn low for 3 cycles, then high -> back to IDLE at count 8, busy low, no frameDone.
REQ-046 Bench SHALL drive 0x3C with the stop bit held low -> frameDone with dataOut=0x3C, frameErr=1.
REQ-047 Bench SHALL set PARITY_EN=1, PARITY_ODD=1 and drive 0x01 with parity bit 1 -> parityErr=1; parity bit 0 -> parityErr=0.
REQ-048 Bench SHALL send two back-to-back frames 0x55 then 0xAA, with a 1-cycle glitch at count 7 of data bit 2 -> dataOut sequence 0x55 then 0xAA, glitch rejected.
REQ-049 Bench SHALL assert rst during data bit 4 -> all outputs 0 on the next cycle; the next clean frame 0x0F is received as 0x0F.
